instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL set the PC loaded on reset.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 i_readM  out  1  SHALL be the instruction-memory read request.
REQ-005 i_address  out  16  SHALL be the word address of the request.
REQ-006 i_ready  in  1  SHALL signal that i_data is valid for the outstanding request.
REQ-007 i_data  in  16  SHALL carry the returned instruction word.
REQ-008 stall  in  1  SHALL signal that decode cannot accept the IF/ID entry this cycle.
REQ-009 is_j_or_b_taken  in  1  SHALL signal an execute-stage redirect.
REQ-010 pc_mux_sel  in  2  SHALL select the redirect target: 00 branch_target, 01 jmp_target, 10 jpr_target, 11 jpr_target.
REQ-011 branch_target, jmp_target, jpr_target  in  16 each  SHALL be the candidate redirect addresses.
REQ-012 if_valid  out  1  SHALL mark the IF/ID entry as valid.
REQ-013 if_instr, if_pc  out  16 each  SHALL hold the fetched instruction and its address.

Function
REQ-014 States SHALL be IDLE, FETCH and DISCARD, plus a 1-entry skid buffer (skid_valid, skid_instr, skid_pc).
REQ-015 In IDLE, i_readM SHALL be 0, and the unit SHALL enter FETCH when the skid buffer is empty and (!if_valid || !stall).
REQ-016 In FETCH, i_readM SHALL be 1 with i_address = PC, held stable until the cycle i_ready = 1.
REQ-017 On i_ready in FETCH with no redirect, PC SHALL become PC+1, wrapping FFFF->0000.
REQ-018 On i_ready in FETCH, the entry SHALL load IF/ID if (!if_valid || !stall), and otherwise the skid buffer.
REQ-019 After i_ready, the unit SHALL stay in FETCH when a new request is allowed (REQ-015 condition after update), and otherwise go to IDLE; back-to-back fetch SHALL give 1 instruction per cycle when i_ready = 1 each cycle.
REQ-020 When !stall and the skid buffer is valid, the skid entry SHALL move to IF/ID and skid_valid SHALL become 0, with the skid taking precedence over any new data.
REQ-021 When stall = 1 and if_valid = 1, the IF/ID outputs SHALL hold unchanged.
REQ-022 When !stall and no new entry is available, if_valid SHALL become 0.
REQ-023 Redirect (is_j_or_b_taken = 1) SHALL have priority over stall and fetch: PC <= selected target, if_valid <= 0, skid_valid <= 0.
REQ-024 A redirect SHALL cause any i_data accepted in the same cycle to be dropped.
REQ-025 After a redirect in FETCH without i_ready that cycle, the unit SHALL enter DISCARD with i_readM = 1 on the old address, drop the data at i_ready, then enter FETCH at the new PC.
REQ-026 A further redirect during DISCARD SHALL update PC only, and the unit SHALL remain in DISCARD.
REQ-027 A redirect in IDLE SHALL load PC, and the unit SHALL fetch from the target the next cycle.

Reset
REQ-028 Asserting reset_n low SHALL asynchronously set PC = RESET_PC, state = IDLE, if_valid = 0, skid_valid = 0, i_readM = 0, and if_instr = if_pc = 0, including mid-transaction.
REQ-029 The first request after reset release SHALL issue on the first clock edge after reset_n rises (i_readM = 1, i_address = RESET_PC).

Configuration
REQ-030 With FETCH_JMP_PREDICT_EN defined, an accepted instruction with opcode bits[15:12] = 9 (JMP) or 10 (JAL) SHALL set the next PC to {if_pc[15:12], instr[11:0]} instead of PC+1.
REQ-031 With FETCH_JMP_PREDICT_EN defined, redirects with pc_mux_sel = 01 SHALL be ignored.
REQ-032 With FETCH_JMP_PREDICT_EN undefined, JMP/JAL SHALL fetch PC+1 sequentially and rely on the execute-stage redirect.

Verification
REQ-033 Reset release, i_ready = 1 every cycle, stall = 0 -> if_pc SHALL show 0000, 0001, 0002 on consecutive cycles with i_readM continuously 1.
REQ-034 stall = 1 for 3 cycles while if_valid = 1 and the next response returns -> IF/ID SHALL hold, the skid SHALL capture, and after stall drops if_pc SHALL advance by exactly 1 with no loss or duplicate.
REQ-035 Redirect to 0040 (pc_mux_sel = 00) while a request to 0005 is outstanding -> DISCARD, the 0005 data SHALL never appear, and the next request SHALL be to 0040.
REQ-036 Redirect coinciding with i_ready -> the data SHALL be dropped, if_valid SHALL be 0 the next cycle, and i_address SHALL equal the target.
REQ-037 PC = FFFF fetch -> the next request address SHALL be 0000.
REQ-038 With the macro defined, fetch 9123 at PC 2010 -> the next i_address SHALL be 2123, and a later pc_mux_sel = 01 redirect SHALL be ignored.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if
// Instruction-memory request/response bus between the fetch unit and the
// instruction memory.
//   i_readM   : read request, held high while a request is outstanding
//   i_address : word address of the outstanding request
//   i_ready   : i_data is valid for the outstanding request this cycle
//   i_data    : returned instruction word
// master = fetch unit side, slave = memory side.
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if;
    logic        i_readM;
    logic [15:0] i_address;
    logic        i_ready;
    logic [15:0] i_data;

    modport master (
        output i_readM,
        output i_address,
        input  i_ready,
        input  i_data
    );

    modport slave (
        input  i_readM,
        input  i_address,
        output i_ready,
        output i_data
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Fetches 16-bit instruction words from instruction memory and presents them
// to decode through an IF/ID register backed by a one-entry skid buffer, so a
// response that arrives while decode is stalled is never lost. Execute-stage
// redirects flush IF/ID and the skid; a redirect that lands while a request is
// still outstanding parks the unit in DISCARD until the stale word returns.
//
// Ports
//   clk, reset_n        : clock, asynchronous active-low reset
//   imem (master)       : i_readM/i_address out, i_ready/i_data in
//   stall               : decode cannot take the IF/ID entry this cycle
//   is_j_or_b_taken     : execute-stage redirect
//   pc_mux_sel          : 00 branch_target, 01 jmp_target, 1x jpr_target
//   branch/jmp/jpr_target : redirect candidates
//   if_valid/if_instr/if_pc : IF/ID entry
//
// Optional feature macro: FETCH_JMP_PREDICT_EN
//   When defined, JMP (opcode 9) and JAL (opcode 10) are followed in fetch
//   ({pc[15:12], instr[11:0]}) and execute redirects with pc_mux_sel = 01 are
//   ignored, since fetch has already gone there. When undefined, JMP/JAL are
//   fetched past sequentially and the execute redirect corrects the path.
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                             clk,
    input  logic                             reset_n,
    instruction_fetch_unit_if.master         imem,
    input  logic                             stall,
    input  logic                             is_j_or_b_taken,
    input  logic [1:0]                       pc_mux_sel,
    input  logic [15:0]                      branch_target,
    input  logic [15:0]                      jmp_target,
    input  logic [15:0]                      jpr_target,
    output logic                             if_valid,
    output logic [15:0]                      if_instr,
    output logic [15:0]                      if_pc
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    // Address of the stale request still in flight while in DISCARD; pc_q
    // already holds the redirect target by then.
    logic [15:0] disc_addr_q, disc_addr_d;

    logic        if_valid_q, if_valid_d;
    logic [15:0] if_instr_q, if_instr_d;
    logic [15:0] if_pc_q, if_pc_d;

    logic        skid_valid_q, skid_valid_d;
    logic [15:0] skid_instr_q, skid_instr_d;
    logic [15:0] skid_pc_q, skid_pc_d;

    logic        redirect;
    logic [15:0] redirect_tgt;
    logic        accept;
    logic        take_ok;
    logic [15:0] next_seq_pc;

    // Redirect target select; 10 and 11 both pick the register-jump target.
    always_comb begin
        redirect_tgt = jpr_target;
        case (pc_mux_sel)
            2'b00:   redirect_tgt = branch_target;
            2'b01:   redirect_tgt = jmp_target;
            default: redirect_tgt = jpr_target;
        endcase
    end

`ifdef FETCH_JMP_PREDICT_EN
    // Direct jumps were already followed in fetch, so their execute-stage
    // redirect would only refetch the same path.
    assign redirect = is_j_or_b_taken && (pc_mux_sel != 2'b01);

    always_comb begin
        if ((imem.i_data[15:12] == 4'd9) || (imem.i_data[15:12] == 4'd10))
            next_seq_pc = {pc_q[15:12], imem.i_data[11:0]};
        else
            next_seq_pc = pc_q + 16'd1;
    end
`else
    assign redirect    = is_j_or_b_taken;
    assign next_seq_pc = pc_q + 16'd1;   // wraps FFFF -> 0000
`endif

    // A response only counts as a live instruction in FETCH; in DISCARD it
    // belongs to the pre-redirect path.
    assign accept  = (state_q == S_FETCH) && imem.i_ready;
    // IF/ID can take a new entry when it is empty or decode is consuming it.
    assign take_ok = !if_valid_q || !stall;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        disc_addr_d  = disc_addr_q;
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (redirect) begin
            // Redirect wins over stall and over any word returned this cycle.
            pc_d         = redirect_tgt;
            if_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
            case (state_q)
                S_IDLE:  state_d = S_FETCH;
                S_FETCH: begin
                    if (imem.i_ready) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d     = S_DISCARD;
                        disc_addr_d = pc_q;
                    end
                end
                // Further redirects only retarget the PC; stay until the
                // stale word has drained (it may drain this very cycle).
                S_DISCARD: state_d = imem.i_ready ? S_FETCH : S_DISCARD;
                default:   state_d = S_IDLE;
            endcase
        end else begin
            // IF/ID and skid movement. The skid is older than any new word,
            // so it always moves first.
            if (take_ok) begin
                if (skid_valid_q) begin
                    if_valid_d   = 1'b1;
                    if_instr_d   = skid_instr_q;
                    if_pc_d      = skid_pc_q;
                    skid_valid_d = 1'b0;
                    if (accept) begin
                        skid_valid_d = 1'b1;
                        skid_instr_d = imem.i_data;
                        skid_pc_d    = pc_q;
                    end
                end else if (accept) begin
                    if_valid_d = 1'b1;
                    if_instr_d = imem.i_data;
                    if_pc_d    = pc_q;
                end else begin
                    if_valid_d = 1'b0;
                end
            end else if (accept) begin
                skid_valid_d = 1'b1;
                skid_instr_d = imem.i_data;
                skid_pc_d    = pc_q;
            end

            if (accept)
                pc_d = next_seq_pc;

            case (state_q)
                S_IDLE: begin
                    if (!skid_valid_q && take_ok)
                        state_d = S_FETCH;
                end
                S_FETCH: begin
                    // Keep streaming only if the updated buffers leave room.
                    if (accept)
                        state_d = (!skid_valid_d && (!if_valid_d || !stall))
                                  ? S_FETCH : S_IDLE;
                end
                S_DISCARD: begin
                    if (imem.i_ready)
                        state_d = S_FETCH;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            disc_addr_q  <= 16'h0000;
            if_valid_q   <= 1'b0;
            if_instr_q   <= 16'h0000;
            if_pc_q      <= 16'h0000;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 16'h0000;
            skid_pc_q    <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            disc_addr_q  <= disc_addr_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    // Request is outstanding in FETCH and while draining in DISCARD.
    assign imem.i_readM   = (state_q != S_IDLE);
    assign imem.i_address = (state_q == S_DISCARD) ? disc_addr_q : pc_q;

    assign if_valid = if_valid_q;
    assign if_instr = if_instr_q;
    assign if_pc    = if_pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Scoreboard bench: each word the memory is expected to deliver to decode is
// pushed as {pc, instr} when its response is scheduled, and popped/compared
// whenever decode consumes IF/ID (if_valid && !stall, no redirect).
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        is_j_or_b_taken;
    logic [1:0]  pc_mux_sel;
    logic [15:0] branch_target;
    logic [15:0] jmp_target;
    logic [15:0] jpr_target;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;

    always #5 clk = ~clk;

    instruction_fetch_unit_if imem ();

    instruction_fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem            (imem),
        .stall           (stall),
        .is_j_or_b_taken (is_j_or_b_taken),
        .pc_mux_sel      (pc_mux_sel),
        .branch_target   (branch_target),
        .jmp_target      (jmp_target),
        .jpr_target      (jpr_target),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          budget      = 0;   // responses the memory may still return
    logic [31:0] sb[$];

    // Instruction memory contents; 2010 holds a JMP, everything else has
    // opcode 1 so nothing else is ever predicted.
    function automatic logic [15:0] mem(input logic [15:0] a);
        if (a == 16'h2010) return 16'h9123;
        return {4'h1, a[11:0] ^ 12'h5A5};
    endfunction

    task automatic push(input logic [15:0] a);
        sb.push_back({a, mem(a)});
    endtask

    task automatic update_resp();
        imem.i_ready = (budget > 0) && (imem.i_readM === 1'b1);
        imem.i_data  = mem(imem.i_address);
    endtask

    task automatic mem_go(input int n);
        budget = n;
        update_resp();
    endtask

    // One clock: consume/compare IF/ID at the negedge, advance, then let the
    // memory answer the request now visible.
    task automatic step();
        logic [31:0] e;
        @(negedge clk);
        if (if_valid === 1'b1 && stall === 1'b0 && is_j_or_b_taken === 1'b0) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_entry: got pc=%h instr=%h, required no entry",
                         if_pc, if_instr);
            end else begin
                e = sb.pop_front();
                if ({if_pc, if_instr} !== e) begin
                    miscompares++;
                    $display("FAIL entry: got pc=%h instr=%h, required pc=%h instr=%h",
                             if_pc, if_instr, e[31:16], e[15:0]);
                end
            end
        end
        if (imem.i_ready === 1'b1) budget--;
        @(posedge clk);
        #1;
        update_resp();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            step();
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d entries left, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic redirect(input logic [1:0] sel, input logic [15:0] tgt);
        pc_mux_sel      = sel;
        branch_target   = (sel == 2'b00) ? tgt : 16'hDEAD;
        jmp_target      = (sel == 2'b01) ? tgt : 16'hBEEF;
        jpr_target      = (sel[1])       ? tgt : 16'hCAFE;
        is_j_or_b_taken = 1'b1;
        step();
        is_j_or_b_taken = 1'b0;
    endtask

    task automatic chk_addr(input string name, input logic [15:0] exp);
        vectors++;
        if (imem.i_readM !== 1'b1 || imem.i_address !== exp) begin
            miscompares++;
            $display("FAIL %s: got readM=%b addr=%h, required readM=1 addr=%h",
                     name, imem.i_readM, imem.i_address, exp);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({imem.i_readM, if_valid, if_pc, if_instr} !== 34'd0) begin
            miscompares++;
            $display("FAIL reset_state: got readM=%b valid=%b pc=%h instr=%h, required all 0",
                     imem.i_readM, if_valid, if_pc, if_instr);
        end
        reset_n = 1'b1;
        step();
        chk_addr("first_request", 16'h0000);
    endtask

    task automatic test_stream();
        for (int k = 0; k < 6; k++) push(16'(k));
        mem_go(6);
        for (int k = 0; k < 6; k++) begin
            chk_addr("stream_addr", 16'(k));
            step();
        end
        drain("stream");
    endtask

    task automatic test_stall_skid();
        push(16'h0006);
        mem_go(1);
        step();
        stall = 1'b1;
        push(16'h0007);
        mem_go(1);
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (if_valid !== 1'b1 || if_pc !== 16'h0006 || imem.i_readM !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold: got valid=%b pc=%h readM=%b, required valid=1 pc=0006 readM=0",
                         if_valid, if_pc, imem.i_readM);
            end
        end
        stall = 1'b0;
        push(16'h0008);
        push(16'h0009);
        mem_go(2);
        drain("stall_skid");
        step();
        step();
    endtask

    task automatic test_redirect_discard();
        redirect(2'b00, 16'h0005);
        chk_addr("discard_old_addr", 16'h000A);
        mem_go(1);
        step();
        chk_addr("refetch_addr", 16'h0005);
        redirect(2'b00, 16'h0040);
        chk_addr("discard_hold_0005", 16'h0005);
        step();
        chk_addr("discard_wait_0005", 16'h0005);
        mem_go(1);
        step();
        chk_addr("after_discard", 16'h0040);
        push(16'h0040);
        mem_go(1);
        drain("redirect_discard");
    endtask

    task automatic test_redirect_ready();
        mem_go(1);
        redirect(2'b10, 16'h0123);
        vectors++;
        if (if_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_ready_valid: got %b, required 0", if_valid);
        end
        chk_addr("redir_ready_addr", 16'h0123);
        push(16'h0123);
        mem_go(1);
        drain("redirect_ready");
    endtask

    task automatic test_discard_reredirect();
        redirect(2'b00, 16'h0200);
        redirect(2'b11, 16'h0300);
        chk_addr("rediscard_addr", 16'h0124);
        mem_go(1);
        step();
        chk_addr("rediscard_target", 16'h0300);
        push(16'h0300);
        mem_go(1);
        drain("rediscard");
    endtask

    task automatic test_wrap();
        mem_go(1);
        redirect(2'b10, 16'hFFFF);
        push(16'hFFFF);
        mem_go(1);
        step();
        chk_addr("wrap_addr", 16'h0000);
        drain("wrap");
    endtask

    task automatic test_jmp();
        mem_go(1);
        redirect(2'b10, 16'h2010);
        push(16'h2010);
        mem_go(1);
        step();
`ifdef FETCH_JMP_PREDICT_EN
        chk_addr("jmp_predict", 16'h2123);
        drain("jmp");
        redirect(2'b01, 16'h0555);
        chk_addr("jmp_redirect_ignored", 16'h2123);
        push(16'h2123);
        mem_go(1);
        drain("jmp_ignored");
`else
        chk_addr("jmp_sequential", 16'h2011);
        drain("jmp");
        redirect(2'b01, 16'h0555);
        mem_go(1);
        step();
        chk_addr("jmp_redirect", 16'h0555);
`endif
    endtask

    task automatic test_reset_mid();
        mem_go(1);
        redirect(2'b10, 16'h0700);
        mem_go(1);
        step();
        stall = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({imem.i_readM, if_valid, if_pc, if_instr} !== 34'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got readM=%b valid=%b pc=%h instr=%h, required all 0",
                     imem.i_readM, if_valid, if_pc, if_instr);
        end
        sb.delete();
        stall = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
        chk_addr("reset_mid_first_req", 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n         = 1'b0;
        stall           = 1'b0;
        is_j_or_b_taken = 1'b0;
        pc_mux_sel      = 2'b00;
        branch_target   = 16'h0000;
        jmp_target      = 16'h0000;
        jpr_target      = 16'h0000;
        imem.i_ready    = 1'b0;
        imem.i_data     = 16'h0000;

        test_reset();
        test_stream();
        test_stall_skid();
        test_redirect_discard();
        test_redirect_ready();
        test_discard_reredirect();
        test_wrap();
        test_jmp();
        test_reset_mid();
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
